alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: XLEN, default 32, datapath width in bits.
REQ-002 clk_i  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  Reset, asynchronous and active-high.
REQ-004 valid_i  input  1  Upstream request valid.
REQ-005 ready_o  output  1  Block can accept a request.
REQ-006 alu_op_i  input  alu_pkg::alu_op_e  Operation: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-007 alu_src1_i  input  alu_pkg::alu_src_e  Operand A select.
REQ-008 alu_src2_i  input  alu_pkg::alu_src_e  Operand B select.
REQ-009 rs1_data_i, rs2_data_i, imm_i, pc_i  input  XLEN each  Candidate operand sources.
REQ-010 valid_o  output  1  Result valid.
REQ-011 ready_i  input  1  Downstream accepts result.
REQ-012 result_o  output  XLEN  Registered result.
REQ-013 zero_o, lt_o, ltu_o  output  1 each  Registered flags: A==B, signed A<B, unsigned A<B.

Function
REQ-014 Operand A SHALL be: REG -> rs1_data_i, PC -> pc_i, IMM -> imm_i, FOUR -> 4, ZERO -> 0.
REQ-015 Operand B SHALL be: REG -> rs2_data_i, PC -> pc_i, IMM -> imm_i, FOUR -> 4, ZERO -> 0.
REQ-016 Operands, op, and flags SHALL be captured only on the accept cycle, valid_i && ready_o.
REQ-017 FSM states: IDLE, SHIFT, DONE; ready_o SHALL be 1 only in IDLE.
REQ-018 IDLE with accept of a non-shift op -> DONE; the result SHALL be registered on the accept edge, giving valid_o one cycle after accept.
REQ-019 IDLE with accept of SLL/SRL/SRA: shift amount = B[4:0]; amount 0 -> DONE with result A; otherwise -> SHIFT.
REQ-020 SHIFT: shift by one bit per cycle (SRA fills with the sign bit) and decrement the counter; -> DONE when the counter reaches 0; valid_o rises amount+1 cycles after accept.
REQ-021 DONE: valid_o=1; result_o and flags SHALL hold stable while ready_i=0; ready_i=1 -> IDLE.
REQ-022 Arithmetic: ADD/SUB SHALL wrap modulo 2^XLEN; SLT/SLTU SHALL yield zero-extended 1/0; shifts SHALL use only B[4:0].
REQ-023 zero_o SHALL compare A and B (not the result), so that a SUB issued for a branch yields zero_o=1 when the operands are equal.
REQ-024 An illegal or unlisted alu_op_i SHALL execute as ADD.
REQ-025 A new request SHALL NOT be accepted in the cycle DONE->IDLE; the earliest next accept is the following cycle.
REQ-026 valid_i SHALL be ignored in SHIFT and DONE; no request is queued.

Reset
REQ-027 rst_i asserted SHALL immediately force IDLE, valid_o=0, ready_o=1, result_o=0, flags=0, shift counter=0.
REQ-028 Reset during SHIFT or DONE SHALL discard the in-flight operation with no result produced.

Configuration
REQ-029 Macro ALU_FAST_SHIFT_EN defined: shifts SHALL use a single-cycle barrel shifter and follow REQ-018 (1-cycle latency); SHIFT state unused.
REQ-030 ALU_FAST_SHIFT_EN undefined: iterative shifting per REQ-019/020; the function SHALL be otherwise identical.

Verification
REQ-031 ADD: src1=REG, src2=IMM, rs1=0x10, imm=0xFFFFFFF0 -> result 0x0, valid_o one cycle after accept.
REQ-032 SUB branch: rs1=rs2=0x80000000 -> result 0, zero_o=1, lt_o=0; then rs1=0xFFFFFFFF, rs2=1 -> lt_o=1, ltu_o=0.
REQ-033 SRA: rs1=0x80000000, rs2=31 -> result 0xFFFFFFFF; valid_o 32 cycles after accept (iterative) or 1 cycle (ALU_FAST_SHIFT_EN).
REQ-034 Backpressure: ready_i=0 for 5 cycles in DONE -> result_o stable, ready_o=0, extra valid_i ignored; ready_i=1 -> IDLE.
REQ-035 Reset mid-SHIFT (SLL by 20, rst_i at cycle 5) -> valid_o=0, ready_o=1 immediately; no result is emitted.
REQ-036 AUIPC/JAL-link: src1=PC, src2=FOUR, pc=0x1000 -> 0x1004; src1=ZERO, src2=IMM, imm=0xABCDE000 -> 0xABCDE000.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle integer ALU with valid/ready handshakes on both sides.
// Non-shift operations complete one cycle after accept. Shifts are iterative
// (one bit per cycle) by default; define ALU_FAST_SHIFT_EN to use a
// single-cycle barrel shifter instead, which leaves the SHIFT state unreachable.
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        SRC_REG  = 3'd0,
        SRC_PC   = 3'd1,
        SRC_IMM  = 3'd2,
        SRC_FOUR = 3'd3,
        SRC_ZERO = 3'd4
    } alu_src_e;
endpackage

module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  alu_op_e         alu_op_i,
    input  alu_src_e        alu_src1_i,
    input  alu_src_e        alu_src2_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            lt_o,
    output logic            ltu_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]      state;
    logic [4:0]      cnt;
    alu_op_e         op_q;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;
    logic            is_shift;
    logic            accept;

    // Unlisted source encodings fall back to zero rather than leaving X.
    function automatic logic [XLEN-1:0] sel_operand(alu_src_e src, logic [XLEN-1:0] rs,
                                                    logic [XLEN-1:0] pc, logic [XLEN-1:0] imm);
        case (src)
            SRC_REG:  return rs;
            SRC_PC:   return pc;
            SRC_IMM:  return imm;
            SRC_FOUR: return XLEN'(4);
            default:  return '0;
        endcase
    endfunction

    assign opa      = sel_operand(alu_src1_i, rs1_data_i, pc_i, imm_i);
    assign opb      = sel_operand(alu_src2_i, rs2_data_i, pc_i, imm_i);
    assign shamt    = opb[4:0];
    assign is_shift = (alu_op_i == ALU_SLL) || (alu_op_i == ALU_SRL) || (alu_op_i == ALU_SRA);
    assign accept   = valid_i && ready_o;
    assign ready_o  = (state == S_IDLE);
    assign valid_o  = (state == S_DONE);

    // Single-cycle result; in the iterative build a shift here only covers amount 0.
    always_comb begin
        // NOTE: default first so every path assigns alu_res and no latch is inferred.
        alu_res = opa + opb;
        case (alu_op_i)
            ALU_SUB:  alu_res = opa - opb;
            ALU_SLT:  alu_res = XLEN'($signed(opa) < $signed(opb));
            ALU_SLTU: alu_res = XLEN'(opa < opb);
            ALU_XOR:  alu_res = opa ^ opb;
            ALU_OR:   alu_res = opa | opb;
            ALU_AND:  alu_res = opa & opb;
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  alu_res = opa << shamt;
            ALU_SRL:  alu_res = opa >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
`else
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = opa;
`endif
            default:  alu_res = opa + opb;
        endcase
    end

    // Control FSM plus result, flag and shift-counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= ALU_ADD;
            result_o <= '0;
            zero_o   <= 1'b0;
            lt_o     <= 1'b0;
            ltu_o    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= alu_op_i;
                        result_o <= alu_res;
                        zero_o   <= (opa == opb);
                        lt_o     <= ($signed(opa) < $signed(opb));
                        ltu_o    <= (opa < opb);
`ifdef ALU_FAST_SHIFT_EN
                        state    <= S_DONE;
`else
                        if (is_shift && (shamt != 5'd0)) begin
                            cnt   <= shamt;
                            state <= S_SHIFT;
                        end else begin
                            state <= S_DONE;
                        end
`endif
                    end
                end
                S_SHIFT: begin
                    case (op_q)
                        ALU_SRL: result_o <= result_o >> 1;
                        ALU_SRA: result_o <= {result_o[XLEN-1], result_o[XLEN-1:1]};
                        default: result_o <= result_o << 1;
                    endcase
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
